// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel FSM state encodings.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axi_lite_mem_array.sv
// Word storage with one byte-enabled synchronous write port and one synchronous read port.
// A read and write to the same word in one cycle returns the pre-write contents.
module axi_lite_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_BITS-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic [ADDR_BITS-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < StrbW; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder over a byte-enabled word memory; independent write and read FSMs,
// one outstanding transaction per channel, out-of-range accesses answer SLVERR.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 2 ** (ADDR_WIDTH - 2)
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = ADDR_WIDTH - OffW;
  localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Byte-offset bits are deliberately ignored: only aligned word access exists.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[OffW-1:0], s_axi_araddr[OffW-1:0]};

  // ---------------- write channel ----------------
  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_cap_q, aw_cap_d;
  logic                  w_cap_q, w_cap_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [IdxW-1:0]       awidx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [StrbW-1:0]      wstrb_q;

  logic                  aw_hs, w_hs, wr_fire, wr_in_range;
  logic [IdxW-1:0]       wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [StrbW-1:0]      wr_strb;

  assign aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  // Bypass the holding registers so the commit can happen on the completing handshake edge.
  assign wr_idx      = aw_cap_q ? awidx_q : s_axi_awaddr[ADDR_WIDTH-1:OffW];
  assign wr_data     = w_cap_q ? wdata_q : s_axi_wdata;
  assign wr_strb     = w_cap_q ? wstrb_q : s_axi_wstrb;
  assign wr_in_range = 32'(wr_idx) < DEPTH;
  assign wr_fire     = (wr_state_q == W_IDLE) && (aw_cap_q || aw_hs) && (w_cap_q || w_hs);

  always_comb begin
    wr_state_d    = wr_state_q;
    aw_cap_d      = aw_cap_q;
    w_cap_d       = w_cap_q;
    bresp_d       = bresp_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        s_axi_awready = !s_axi_areset && !aw_cap_q;
        s_axi_wready  = !s_axi_areset && !w_cap_q;
        if (aw_hs) aw_cap_d = 1'b1;
        if (w_hs)  w_cap_d  = 1'b1;
        if (wr_fire) begin
          bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = !s_axi_areset;
        if (s_axi_bready) begin
          aw_cap_d   = 1'b0;
          w_cap_d    = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wr_state_q <= W_IDLE;
      aw_cap_q   <= 1'b0;
      w_cap_q    <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_cap_q   <= aw_cap_d;
      w_cap_q    <= w_cap_d;
      bresp_q    <= bresp_d;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (aw_hs) awidx_q <= s_axi_awaddr[ADDR_WIDTH-1:OffW];
    if (w_hs) begin
      wdata_q <= s_axi_wdata;
      wstrb_q <= s_axi_wstrb;
    end
  end

  assign s_axi_bresp = bresp_q;

  // ---------------- read channel ----------------
  rd_state_t             rd_state_q, rd_state_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_hs, rd_in_range;
  logic [IdxW-1:0]       rd_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign rd_idx      = s_axi_araddr[ADDR_WIDTH-1:OffW];
  assign rd_in_range = 32'(rd_idx) < DEPTH;

  always_comb begin
    rd_state_d    = rd_state_q;
    rresp_d       = rresp_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        s_axi_arready = !s_axi_areset;
        if (ar_hs) begin
          rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        s_axi_rvalid = !s_axi_areset;
        if (s_axi_rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rd_state_q <= R_IDLE;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rresp_q    <= rresp_d;
    end
  end

  // The array's read register only loads on an accepted AR, so it holds through R_DATA.
  assign s_axi_rdata = (s_axi_rvalid && rresp_q == RESP_OKAY) ? mem_rdata : '0;
  assign s_axi_rresp = rresp_q;

  axi_lite_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_BITS (MemAw)
  ) u_mem (
    .clk  (s_axi_aclk),
    .we   (wr_fire && wr_in_range),
    .waddr(wr_idx[MemAw-1:0]),
    .wdata(wr_data),
    .wstrb(wr_strb),
    .re   (ar_hs && rd_in_range),
    .raddr(rd_idx[MemAw-1:0]),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave; expected responses queued at issue, checked by monitors.
module tb_axi_lite_mem_slave;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  int b_seen = 0;
  int r_seen = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  always #5 clk = ~clk;

  axi_lite_mem_slave #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .DEPTH     (48)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (areset),
    .s_axi_awaddr (awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready)
  );

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitors: sample on the falling edge, a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got bresp %h expected no response", bresp);
      end else begin
        check("bresp", 34'(bresp), 34'(exp_b.pop_front()));
      end
      b_seen++;
    end
    if (rvalid && rready) begin
      if (exp_r.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r_unexpected: got %h/%h expected no response", rdata, rresp);
      end else begin
        check("rdata_rresp", {rdata, rresp}, exp_r.pop_front());
      end
      r_seen++;
    end
  end

  task automatic wait_b(input int start);
    int n = 0;
    while (b_seen == start && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("b_handshake", 34'(b_seen > start), 34'(1));
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    int n = 0;
    int bs0 = b_seen;
    exp_b.push_back(resp);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      n++;
    end
    check("aw_w_accept", 34'(aw_done && w_done), 34'(1));
    @(negedge clk);
    check("b_latency", 34'(bvalid), 34'(1));
    wait_b(bs0);
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] resp);
    bit done = 0;
    int n = 0;
    int rs0 = r_seen;
    exp_r.push_back({d, resp});
    araddr = a; arvalid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      if (arvalid && arready) done = 1;
      @(posedge clk); #1;
      if (done) arvalid = 1'b0;
      n++;
    end
    check("ar_accept", 34'(done), 34'(1));
    @(negedge clk);
    check("r_latency", 34'(rvalid), 34'(1));
    n = 0;
    while (r_seen == rs0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("r_handshake", 34'(r_seen > rs0), 34'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs0;
    int k;
    areset = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readies", 34'({awready, wready, arready}), 34'(0));
    check("rst_valids", 34'({bvalid, rvalid}), 34'(0));
    check("rst_resp_data", {rdata, bresp}, 34'(0));
    check("rst_rresp", 34'(rresp), 34'(0));
    @(posedge clk); #1 areset = 1'b0;
    @(negedge clk);
    check("post_rst_readies", 34'({awready, wready, arready}), 34'(3'b111));
    @(posedge clk); #1;

    // Basic write then read
    axi_write(8'h04, 32'hDEADBEEF, 4'hF, 2'b00);
    axi_read(8'h04, 32'hDEADBEEF, 2'b00);

    // W two cycles ahead of AW
    exp_b.push_back(2'b00);
    bs0 = b_seen;
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("w_first_ready", 34'(wready), 34'(1));
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk);
    check("wready_drop", 34'(wready), 34'(0));
    check("no_b_without_aw", 34'(bvalid), 34'(0));
    @(posedge clk); #1 awaddr = 8'h08; awvalid = 1'b1;
    @(negedge clk);
    check("aw_late_ready", 34'(awready), 34'(1));
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    check("b_after_aw", 34'(bvalid), 34'(1));
    wait_b(bs0);
    axi_read(8'h08, 32'h11223344, 2'b00);

    // Byte strobes
    axi_write(8'h0C, 32'hFFFFFFFF, 4'hF, 2'b00);
    axi_write(8'h0C, 32'h000000AB, 4'h1, 2'b00);
    axi_read(8'h0C, 32'hFFFFFFAB, 2'b00);

    // Range boundary: word 47 valid, word 48 out of range and not aliased onto word 0
    axi_write(8'h00, 32'h01020304, 4'hF, 2'b00);
    axi_write(8'hBC, 32'h4747C0DE, 4'hF, 2'b00);
    axi_write(8'hC0, 32'hBAD0BAD0, 4'hF, 2'b10);
    axi_read(8'h00, 32'h01020304, 2'b00);
    axi_read(8'hBC, 32'h4747C0DE, 2'b00);
    axi_read(8'hC0, 32'h00000000, 2'b10);
    axi_read(8'hFC, 32'h00000000, 2'b10);

    // Backpressure on B while a read runs on the other channel
    bready = 1'b0;
    fork
      axi_write(8'h14, 32'hA5A5A5A5, 4'hF, 2'b00);
      begin
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!bvalid && k < 20);
        for (int i = 0; i < 5; i++) begin
          check("bp_bvalid_held", 34'(bvalid), 34'(1));
          check("bp_no_accept", 34'({awready, wready}), 34'(0));
          check("bp_bresp_held", 34'(bresp), 34'(0));
          @(negedge clk);
        end
        @(posedge clk); #1 bready = 1'b1;
      end
      axi_read(8'h04, 32'hDEADBEEF, 2'b00);
    join
    axi_read(8'h14, 32'hA5A5A5A5, 2'b00);

    // Same-cycle write and read of one word returns the old data
    axi_write(8'h10, 32'h55555555, 4'hF, 2'b00);
    fork
      axi_write(8'h10, 32'h66666666, 4'hF, 2'b00);
      axi_read(8'h10, 32'h55555555, 2'b00);
    join
    axi_read(8'h10, 32'h66666666, 2'b00);

    // Reset with AW captured and W pending
    axi_write(8'h18, 32'h77777777, 4'hF, 2'b00);
    awaddr = 8'h18; awvalid = 1'b1;
    @(negedge clk);
    check("mid_aw_ready", 34'(awready), 34'(1));
    @(posedge clk); #1 awvalid = 1'b0; areset = 1'b1;
    @(negedge clk);
    check("mid_rst_bvalid", 34'(bvalid), 34'(0));
    check("mid_rst_readies", 34'({awready, wready, arready}), 34'(0));
    @(posedge clk); #1 areset = 1'b0;
    @(negedge clk);
    check("mid_post_readies", 34'({awready, wready, arready}), 34'(3'b111));
    check("mid_post_bvalid", 34'(bvalid), 34'(0));
    // A lone W must not complete the discarded AW
    wdata = 32'h99999999; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk);
    check("lone_w_no_b", 34'(bvalid), 34'(0));
    exp_b.push_back(2'b00);
    bs0 = b_seen;
    @(posedge clk); #1 awaddr = 8'h1C; awvalid = 1'b1;
    @(negedge clk);
    check("late_aw_ready", 34'(awready), 34'(1));
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    check("late_aw_b", 34'(bvalid), 34'(1));
    wait_b(bs0);
    axi_read(8'h18, 32'h77777777, 2'b00);
    axi_read(8'h1C, 32'h99999999, 2'b00);

    repeat (3) @(posedge clk);
    check("b_queue_empty", 34'(exp_b.size()), 34'(0));
    check("r_queue_empty", 34'(exp_r.size()), 34'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
